// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor on the reference clock: pulses the PLL reset, qualifies lock and
// releases system reset. Optional retry limit and failure latch via `define PLL_RETRY_LIMIT_EN.
module pll_lock_supervisor #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 1000000,
   parameter int unsigned STABLE_CYCLES = 4096,
   parameter int unsigned RETRY_MAX     = 7
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_reset_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       pll_ok,
   output logic [1:0] state,
   output logic [7:0] lock_lost_cnt,
   output logic       pll_fail
);

   localparam int unsigned MaxRs    = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
   localparam int unsigned CntMax   = (LOCK_TIMEOUT > MaxRs) ? LOCK_TIMEOUT : MaxRs;
   localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;

   if (RST_CYCLES == 0 || LOCK_TIMEOUT == 0 || STABLE_CYCLES == 0 || RETRY_MAX > 255) begin : g_param_check
      $error("pll_lock_supervisor: parameter out of range");
   end

   typedef enum logic [1:0] {
      StResetPll = 2'd0,
      StWaitLock = 2'd1,
      StStable   = 2'd2,
      StRun      = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        lost_q, lost_d;
   logic              lk_meta_q, lk_s_q;
   logic              pll_rst_q, sys_rst_n_q, pll_ok_q;
   logic              failed;

`ifdef PLL_RETRY_LIMIT_EN
   localparam int unsigned RetryW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   logic [RetryW-1:0] retry_q, retry_d;
   logic              fail_q, fail_d;
   assign failed = fail_q;
`else
   assign failed = 1'b0;
`endif

   // pll_locked is asynchronous to refclk; only lk_s_q feeds decisions
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         lk_meta_q <= 1'b0;
         lk_s_q    <= 1'b0;
      end else begin
         lk_meta_q <= pll_locked;
         lk_s_q    <= lk_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      lost_d  = lost_q;
      cnt_d   = cnt_q;
`ifdef PLL_RETRY_LIMIT_EN
      retry_d = retry_q;
      fail_d  = fail_q;
`endif
      if (soft_reset_req) begin
         state_d = StResetPll;
`ifdef PLL_RETRY_LIMIT_EN
         retry_d = '0;
         fail_d  = 1'b0;
`endif
      end else begin
         unique case (state_q)
            StResetPll: begin
               if (!failed && cnt_q == CntW'(RST_CYCLES - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
               // lock seen on the timeout cycle still wins
               if (lk_s_q) begin
                  state_d = StStable;
               end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
                  state_d = StResetPll;
`ifdef PLL_RETRY_LIMIT_EN
                  if (retry_q == RetryW'(RETRY_MAX)) fail_d = 1'b1;
                  else retry_d = retry_q + 1'b1;
`endif
               end
            end
            StStable: begin
               if (!lk_s_q) state_d = StWaitLock;
               else if (cnt_q == CntW'(STABLE_CYCLES - 1)) state_d = StRun;
            end
            StRun: begin
               if (!lk_s_q) begin
                  state_d = StResetPll;
                  if (lost_q != 8'hff) lost_d = lost_q + 8'd1;
               end
            end
            default: state_d = StResetPll;
         endcase
      end
`ifdef PLL_RETRY_LIMIT_EN
      if (state_d == StRun) retry_d = '0;
`endif
      // counter restarts on any transition (and on soft reset); frozen in RUN and when failed
      if (soft_reset_req || state_d != state_q) cnt_d = '0;
      else if (state_q != StRun && !failed) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StResetPll;
         cnt_q       <= '0;
         lost_q      <= 8'd0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         pll_ok_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lost_q      <= lost_d;
         pll_rst_q   <= (state_d == StResetPll);
         sys_rst_n_q <= (state_d == StRun);
         pll_ok_q    <= (state_d == StRun);
      end
   end

`ifdef PLL_RETRY_LIMIT_EN
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         retry_q <= '0;
         fail_q  <= 1'b0;
      end else begin
         retry_q <= retry_d;
         fail_q  <= fail_d;
      end
   end
`endif

   assign pll_rst       = pll_rst_q;
   assign sys_rst_n     = sys_rst_n_q;
   assign pll_ok        = pll_ok_q;
   assign state         = state_q;
   assign lock_lost_cnt = lost_q;
   assign pll_fail      = failed;

endmodule
